// File: rtl/clkgen_nco_multi.sv
// clkgen_nco_multi: NUM_CH runtime-reprogrammable NCO clock enables/divided clocks with lock tracking
// refclk/rst: clock and sync active-high reset; cfg_valid/cfg_ready/cfg_ch/cfg_inc/cfg_err: increment
// reconfiguration handshake; sync_req: zero all phases while locked; outclk/tick/locked: channel outputs.
module clkgen_nco_multi #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 24,
  parameter int LOCK_CYCLES = 16,
  parameter logic [ACC_W-1:0] DEF_INC = {2'b01, {(ACC_W-2){1'b0}}}
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);
  localparam int CW = $clog2(LOCK_CYCLES + 1);
  typedef enum logic [1:0] {LOCKING, LOCKED, APPLY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] ch_q;
  logic [ACC_W-1:0] inc_q;
  logic accept, ch_ok, clear;
  assign accept = cfg_valid & cfg_ready;
  assign ch_ok = {1'b0, cfg_ch} < 5'(NUM_CH);
  // any accept (even a rejected one) takes priority over sync_req
  assign clear = state == APPLY || (state == LOCKED && sync_req && !accept);
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= LOCKING;
      cnt <= '0;
      locked <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err <= 1'b0;
      ch_q <= '0;
      inc_q <= '0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        LOCKING: begin
          if (cnt == CW'(LOCK_CYCLES - 1)) begin
            state <= LOCKED;
            locked <= 1'b1;
            cfg_ready <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        LOCKED: begin
          if (accept && ch_ok) begin
            state <= APPLY;
            locked <= 1'b0;
            cfg_ready <= 1'b0;
            ch_q <= cfg_ch;
            inc_q <= cfg_inc;
          end else if (accept) cfg_err <= 1'b1;
        end
        default: begin
          state <= LOCKING;
          cnt <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] acc, inc;
    logic [ACC_W:0] sum;
    logic t;
    assign sum = {1'b0, acc} + {1'b0, inc};
    assign outclk[i] = acc[ACC_W-1];
    assign tick[i] = t;
    always_ff @(posedge refclk) begin
      if (rst) begin
        acc <= '0;
        inc <= DEF_INC;
        t <= 1'b0;
      end else begin
        acc <= clear ? '0 : sum[ACC_W-1:0];
        t <= !clear && sum[ACC_W];
        if (state == APPLY && ch_q == 4'(i)) inc <= inc_q;
      end
    end
  end
endmodule

// File: tb/tb_clkgen_nco_multi.sv
// tb_clkgen_nco_multi: directed table-driven bench for clkgen_nco_multi
module tb_clkgen_nco_multi;
  logic refclk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, sync_req = 1'b0;
  logic cfg_ready, cfg_err, locked;
  logic [3:0] cfg_ch = '0, outclk, tick;
  logic [23:0] cfg_inc = '0;
  int passed = 0, total = 0;
  typedef struct {
    logic [3:0] ch;
    logic [23:0] inc;
    bit ok;
    logic [3:0][7:0] exp_t;
  } vec_t;
  vec_t vecs[6];
  clkgen_nco_multi dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_err(cfg_err), .sync_req(sync_req),
    .outclk(outclk), .tick(tick), .locked(locked)
  );
  always #5 refclk = ~refclk;
  task automatic step();
    @(posedge refclk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  task automatic wait_lock(output int n);
    n = 0;
    while (!locked && n < 100) begin
      step();
      n++;
    end
  endtask
  task automatic cfg_accept(input logic [3:0] ch, input logic [23:0] inc, input logic sy);
    int n = 0;
    while (!cfg_ready && n < 500) begin
      step();
      n++;
    end
    chk("cfg_ready_wait", 32'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_ch = ch;
    cfg_inc = inc;
    sync_req = sy;
    step();
    cfg_valid = 1'b0;
    sync_req = 1'b0;
    cfg_ch = 4'($urandom);
    cfg_inc = 24'($urandom);
  endtask
  task automatic count_ticks(input string name, input logic [3:0][7:0] exp_t);
    int cnt[4] = '{0, 0, 0, 0};
    for (int k = 0; k < 32; k++) begin
      step();
      for (int c = 0; c < 4; c++) cnt[c] += int'(tick[c]);
    end
    for (int c = 0; c < 4; c++) chk($sformatf("%s_ticks_ch%0d", name, c), 32'(cnt[c]), 32'(exp_t[c]));
  endtask
  initial begin
    int n, low, first1, bad;
    logic held;
    vecs[0] = '{4'd1, 24'h600000, 1'b1, {8'd8, 8'd8, 8'd12, 8'd8}};
    vecs[1] = '{4'd7, 24'h123456, 1'b0, {8'd8, 8'd8, 8'd12, 8'd8}};
    vecs[2] = '{4'd2, 24'h000000, 1'b1, {8'd8, 8'd0, 8'd12, 8'd8}};
    vecs[3] = '{4'd2, 24'h200000, 1'b1, {8'd8, 8'd4, 8'd12, 8'd8}};
    vecs[4] = '{4'd0, 24'h400000, 1'b1, {8'd8, 8'd4, 8'd12, 8'd8}};
    vecs[5] = '{4'd3, 24'h200000, 1'b1, {8'd4, 8'd4, 8'd12, 8'd8}};
    repeat (3) step();
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ready", 32'(cfg_ready), 0);
    chk("rst_tick_outclk", {tick, outclk}, 0);
    chk("rst_err", 32'(cfg_err), 0);
    rst = 1'b0;
    wait_lock(n);
    chk("lock_edges_after_rst", 32'(n), 16);
    chk("ready_with_lock", 32'(cfg_ready), 1);
    chk("lock_tick_all", 32'(tick), 32'hF);
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (tick !== ((k % 4 == 0) ? 4'hF : 4'h0)) bad++;
      if (outclk !== ((k % 4 >= 2) ? 4'hF : 4'h0)) bad++;
    end
    chk("default_div4_pattern", 32'(bad), 0);
    for (int i = 0; i < 6; i++) begin
      cfg_accept(vecs[i].ch, vecs[i].inc, 1'b0);
      if (vecs[i].ok) begin
        chk($sformatf("v%0d_no_err", i), 32'(cfg_err), 0);
        chk($sformatf("v%0d_ready_drop", i), 32'(cfg_ready), 0);
        low = 0;
        first1 = 0;
        while (!locked && low < 100) begin
          low++;
          step();
          if (low == 1) chk($sformatf("v%0d_apply_clear", i), {tick, outclk}, 0);
          if (first1 == 0 && tick[1]) first1 = low - 1;
        end
        chk($sformatf("v%0d_locked_low", i), 32'(low), 17);
        chk($sformatf("v%0d_ch1_first_tick", i), 32'(first1), 3);
      end else begin
        chk($sformatf("v%0d_err_pulse", i), 32'(cfg_err), 1);
        chk($sformatf("v%0d_err_locked", i), 32'(locked), 1);
        chk($sformatf("v%0d_err_ready", i), 32'(cfg_ready), 1);
        step();
        chk($sformatf("v%0d_err_one_cycle", i), 32'(cfg_err), 0);
      end
      count_ticks($sformatf("v%0d", i), vecs[i].exp_t);
      if (i == 2) begin
        held = outclk[2];
        bad = 0;
        for (int k = 0; k < 100; k++) begin
          step();
          if (tick[2] !== 1'b0 || outclk[2] !== held) bad++;
        end
        chk("frozen_ch2", 32'(bad), 0);
      end
    end
    repeat (5) step();
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    chk("sync_clear", {tick, outclk}, 0);
    chk("sync_locked", 32'(locked), 1);
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (tick[0] !== (k % 4 == 0)) bad++;
      if (tick[3] !== (k % 8 == 0)) bad++;
    end
    chk("sync_align_ch0_ch3", 32'(bad), 0);
    cfg_accept(4'd0, 24'h400000, 1'b0);
    repeat (3) step();
    chk("locking_outclk0_pre", 32'(outclk[0]), 1);
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    chk("locking_sync_ignored", {30'd0, outclk[0], tick[1]}, 32'h3);
    wait_lock(n);
    chk("locking_sync_lock_edges", 32'(n), 13);
    cfg_accept(4'd3, 24'h200000, 1'b1);
    chk("cfg_sync_locked_drop", 32'(locked), 0);
    step();
    chk("cfg_sync_apply_clear", {tick, outclk}, 0);
    wait_lock(n);
    chk("cfg_sync_lock_edges", 32'(n), 16);
    cfg_accept(4'd1, 24'h600000, 1'b0);
    repeat (6) step();
    rst = 1'b1;
    step();
    chk("midlock_rst", {22'd0, locked, cfg_ready, tick, outclk}, 0);
    rst = 1'b0;
    wait_lock(n);
    chk("midlock_rst_lock_edges", 32'(n), 16);
    count_ticks("post_rst", {8'd8, 8'd8, 8'd8, 8'd8});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/clkgen_nco_multi.md
Name: clkgen_nco_multi

Overview:
- Digital successor to the fixed four-output video PLL wrapper.
- Generates NUM_CH independent, runtime-reprogrammable fractional clock enables and divided clocks from one reference clock. Each channel uses a phase accumulator (NCO).
- Adds per-channel frequency reconfiguration through a valid/ready handshake, a realign-to-zero phase sync, and a locked indication that drops and re-asserts around every reconfiguration.
- Sits beside the PLL. It feeds pixel/sample-rate enables to the VGA and capture pipelines, which all stay in the refclk domain.

Parameters:
NUM_CH, 4, number of output channels (1..16)
ACC_W, 24, phase accumulator width in bits (8..32)
LOCK_CYCLES, 16, cycles from reset release or config apply to locked assertion (>=1)
DEF_INC, 2**(ACC_W-2), reset increment loaded into every channel (refclk/4)

Ports:
refclk  in  1  reference clock; all logic on its rising edge
rst  in  1  synchronous active-high reset
cfg_valid  in  1  config request valid
cfg_ready  out  1  config can be accepted
cfg_ch  in  4  target channel index
cfg_inc  in  ACC_W  new phase increment for cfg_ch
cfg_err  out  1  one-cycle pulse: accepted cfg_ch >= NUM_CH
sync_req  in  1  realign all channel phases to zero
outclk  out  NUM_CH  divided clocks, bit i = MSB of acc[i]
tick  out  NUM_CH  one-cycle enable per accumulator wrap
locked  out  1  outputs stable at programmed frequencies

Behaviour:
- Clock and reset: one clock (refclk). Reset (rst) is synchronous and active-high.
- Reset state, while rst is high and on the edge it is sampled:
  - acc[i]=0, inc[i]=DEF_INC, outclk=0, tick=0, locked=0, cfg_ready=0, cfg_err=0.
  - FSM enters LOCKING with the counter at 0.
- Accumulator, every edge when not cleared: {carry,acc[i]} <= acc[i]+inc[i], modulo 2^ACC_W.
  - tick[i] is registered and equals that carry, so it is high for exactly the cycle after the wrapping add.
  - outclk[i] = acc[i][ACC_W-1], registered.
  - Average tick rate = f_refclk*inc/2^ACC_W.
- inc[i]=0: channel frozen. tick[i] stays 0 and outclk[i] holds its value.
- FSM states LOCKING, LOCKED, APPLY:
  - LOCKING: the counter increments every cycle. When it reaches LOCKING_CYCLES-1, go to LOCKED and set locked=1 on that edge.
    - locked therefore rises on the LOCK_CYCLES-th edge after rst is sampled low.
    - Accumulators run normally. cfg_ready=0. sync_req is ignored.
  - LOCKED: cfg_ready=1. On cfg_valid&cfg_ready (accept):
    - if cfg_ch<NUM_CH, go to APPLY;
    - else pulse cfg_err next cycle and stay LOCKED, with no state change and locked still 1.
  - APPLY (one cycle):
    - inc[cfg_ch] <= latched cfg_inc.
    - All acc cleared to 0 and all tick forced to 0 that cycle.
    - locked <= 0, counter <= 0, then go to LOCKING.
    - cfg_ch/cfg_inc are latched at accept and need not be held afterwards.
- sync_req in LOCKED and no accept that cycle:
  - all acc <= 0 next edge, tick forced 0 for that edge.
  - locked stays 1; no handshake.
  - Outside LOCKED it is ignored.
- Simultaneous accept and sync_req: the accept wins; APPLY clears the phases anyway.
- rst mid-APPLY or mid-LOCKING: full reset values apply. Any pending config is lost and inc reverts to DEF_INC.
- cfg_ready is deasserted from the accept edge until locked re-asserts, so at most one config is in flight.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset release, defaults (inc=0x400000):
   - locked rises on the 16th edge after rst is low.
   - Every channel ticks every 4th cycle.
   - outclk has period 4, high 2 cycles.
   - cfg_ready=1 with locked.
2. Reprogram ch1 to inc=0x600000:
   - After accept: locked=0 for 17 cycles (APPLY+16), and all acc=0 on the APPLY edge.
   - Then ch1 gives exactly 3 ticks per 8 cycles, 0x600000 per step, first tick on the 3rd edge.
   - ch0/2/3 unchanged at the /4 rate.
3. cfg_ch=7 with NUM_CH=4:
   - cfg_err pulses one cycle.
   - locked stays 1 and no inc changes.
   - The next valid config is accepted immediately.
4. Program ch2 with inc=0:
   - tick[2]=0 for 100 cycles and outclk[2] constant.
   - Restoring inc=0x200000 gives one tick every 8 cycles.
5. Set ch0=0x400000 and ch3=0x200000, wait several cycles, assert sync_req:
   - all acc=0 next edge, no tick that edge, locked stays 1.
   - Then ch0 and ch3 ticks coincide every 8 cycles.
   - sync_req asserted while LOCKING has no effect.
6. Edge cases:
   - cfg_valid together with sync_req: the config is applied and locked drops.
   - rst asserted 5 cycles into LOCKING after a config: all inc=DEF_INC and locked rises 16 edges after rst is released.
